ddr3_lane_dly_step_ctrl: RTL
============================

// Module: ddr3_lane_dly_step_ctrl
// PURPOSE
//  Upstream sequencer for one DDR3 lane controller's DQS delay lines (RX/TX). Turns a single
//  move/load request from the training FSM into properly timed DELAY_LINE_SEL/DIRECTION/LOAD/MOVE
//  strobes. Enforces setup and inter-move spacing, counts steps and stops on out-of-range.
//  Reports a done strobe with status. One instance per lane, driving that lane's LANECTRL inputs.
// PARAMETERS
//  SETUP_CYC  2    cycles SEL/DIRECTION held stable before the first LOAD/MOVE pulse (1..15)
//  MOVE_GAP   4    idle cycles after every LOAD/MOVE pulse before OOR is sampled (1..15)
//  TAP_MAX    255  highest legal tap index, used by tap tracking only
//  LOAD_VAL   1    tap value the delay line takes on LOAD; matches the lane's *_DQS_DELAY_VAL
// PORTS
//  FAB_CLK                     in   1  fabric clock; all logic on rising edge
//  ARST_N                      in   1  asynchronous active-low reset
//  REQ_VALID                   in   1  request valid
//  REQ_READY                   out  1  high only in IDLE
//  REQ_OP                      in   1  0=MOVE, 1=LOAD
//  REQ_SEL                     in   1  0=RX DQS line, 1=TX DQS line
//  REQ_DIR                     in   1  1=increment delay, 0=decrement
//  REQ_STEPS                   in   8  number of MOVE pulses; ignored for LOAD
//  RX_DELAY_LINE_OUT_OF_RANGE  in   1  from lane controller
//  TX_DELAY_LINE_OUT_OF_RANGE  in   1  from lane controller
//  DELAY_LINE_SEL              out  1  to lane controller
//  DELAY_LINE_DIRECTION        out  1  to lane controller
//  DELAY_LINE_LOAD             out  1  to lane controller; 1-cycle pulse
//  DELAY_LINE_MOVE             out  1  to lane controller; 1-cycle pulse
//  DONE                        out  1  1-cycle completion strobe
//  STATUS                      out  2  valid with DONE: 00 ok, 01 hw OOR, 10 clamp
//  MOVES_DONE                  out  8  MOVE pulses issued by the last request; valid with DONE
//  TAP_RX, TAP_TX              out  8  tracked tap values (see CONFIGURATION)
// BEHAVIOUR
//  Reset: ARST_N low forces IDLE at once, whatever state the FSM is in.
//   All outputs go to 0 except REQ_READY=1, and TAP_RX/TAP_TX=LOAD_VAL.
//   Reset mid-request abandons it. No DONE is produced.
//  IDLE: REQ_READY=1. On REQ_VALID=1 latch op/sel/dir/steps, clear MOVES_DONE, and drive
//   DELAY_LINE_SEL=REQ_SEL and DELAY_LINE_DIRECTION=REQ_DIR from the next cycle. Go to SETUP.
//   SEL/DIRECTION keep their last values in IDLE.
//  SETUP: held exactly SETUP_CYC cycles. Exit: LOAD -> PULSE; MOVE with steps=0 -> DONE (status 00).
//   Otherwise -> PULSE, unless the clamp condition holds, in which case -> DONE (status 10).
//  PULSE: one cycle, LOAD=1 or MOVE=1, never both. MOVE decrements remaining steps,
//   increments MOVES_DONE and updates the tracked tap (+1 if dir=1, else -1).
//   LOAD sets the selected tap to LOAD_VAL. Always -> GAP.
//  GAP: MOVE_GAP cycles. On its last cycle sample the OOR input of the selected line only.
//   OOR=1 -> DONE, status 01 (takes priority over completion).
//   Else LOAD or remaining=0 -> DONE, status 00.
//   Else the clamp condition holds -> DONE, status 10; otherwise -> PULSE.
//  DONE: DONE=1 for one cycle with STATUS/MOVES_DONE; MOVES_DONE holds afterwards. -> IDLE.
//   REQ_READY=0 in DONE, so a back-to-back request is accepted on the cycle after DONE.
//  Clamp condition: tracked tap = TAP_MAX with dir=1, or 0 with dir=0; no pulse is issued.
//  Pulse spacing: consecutive MOVE pulses are exactly MOVE_GAP+1 cycles apart.
//   MOVE latency from request accept to first pulse = SETUP_CYC+1 cycles.
//  REQ_VALID while REQ_READY=0 is ignored; nothing queues. Request fields are don't-care when REQ_VALID=0.
// CONFIGURATION
//  DDR_DLY_TAP_TRACK_EN defined: TAP_RX/TAP_TX are kept as described and the clamp is active;
//   status 10 is possible.
//  Not defined: no tap registers; TAP_RX/TAP_TX are tied to 0 and the clamp check is removed.
//   Only hardware OOR stops a MOVE, so STATUS is never 10.
// TESTING
//  1 Reset, then MOVE sel=0 dir=1 steps=3: 3 MOVE pulses, first 3 cycles after accept, 5 cycles apart.
//    Then DONE with STATUS=00, MOVES_DONE=3, TAP_RX=4.
//  2 LOAD sel=1 after a TX move: one LOAD pulse, no MOVE; DONE STATUS=00; TAP_TX=1.
//  3 MOVE sel=0 steps=10 with RX OOR raised after the 4th pulse: DONE STATUS=01, MOVES_DONE=4.
//    TX OOR is held high throughout and must be ignored.
//  4 (_EN) MOVE sel=0 dir=0 steps=5 from TAP_RX=1: exactly 1 pulse; DONE STATUS=10, MOVES_DONE=1, TAP_RX=0.
//  5 Request during GAP is ignored.
//    ARST_N pulsed low mid-GAP: outputs go to 0 within the same cycle, no DONE follows, REQ_READY=1.
//  6 steps=0 MOVE: no pulse; DONE STATUS=00 at SETUP_CYC+1 cycles after accept.
//    A new request in the cycle after DONE is accepted.

Source files
------------

// File: rtl/ddr3_lane_dly_step_ctrl.sv
// ddr3_lane_dly_step_ctrl
// Sequences one DDR3 lane's DQS delay-line controls (RX/TX) from a single move/load request.
// It holds SEL/DIRECTION stable for SETUP_CYC cycles before the first strobe, then issues
// LOAD/MOVE pulses spaced MOVE_GAP+1 cycles apart. It stops on the selected line's
// out-of-range flag, or on the tracked-tap clamp, and finishes with a one-cycle DONE strobe
// carrying STATUS and MOVES_DONE.
// Optional feature: define DDR_DLY_TAP_TRACK_EN to keep TAP_RX/TAP_TX tap trackers and
// enable the clamp (STATUS 10). Without it, TAP_RX/TAP_TX read 0 and only the hardware
// out-of-range flag can stop a MOVE request early.
module ddr3_lane_dly_step_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int MOVE_GAP  = 4,
  parameter int TAP_MAX   = 255,
  parameter int LOAD_VAL  = 1
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_OP,
  input  logic       REQ_SEL,
  input  logic       REQ_DIR,
  input  logic [7:0] REQ_STEPS,
  input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_SEL,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DONE,
  output logic [1:0] STATUS,
  output logic [7:0] MOVES_DONE,
  output logic [7:0] TAP_RX,
  output logic [7:0] TAP_TX
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] STS_OK    = 2'b00;
  localparam logic [1:0] STS_OOR   = 2'b01;
  localparam logic [1:0] STS_CLAMP = 2'b10;

  // Terminal counts of the SETUP and GAP dwell counters (counter starts at 0 on entry).
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] GAP_LAST   = 4'(MOVE_GAP - 1);
  localparam logic [7:0] TAP_TOP    = 8'(TAP_MAX);
  localparam logic [7:0] TAP_LOAD   = 8'(LOAD_VAL);

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  status_s;
  logic        op_r;
  logic        sel_r;
  logic        dir_r;
  logic [7:0]  rem_r;
  logic [3:0]  cnt_r;
  logic        setup_end_s;
  logic        gap_end_s;
  logic        oor_s;
  logic        clamp_s;
  logic        accept_s;
  logic        pulse_entry_s;

  // Only the line this request addresses may stop it; the other line's flag is ignored.
  assign oor_s         = sel_r ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
  assign setup_end_s   = (cnt_r == SETUP_LAST);
  assign gap_end_s     = (cnt_r == GAP_LAST);
  assign accept_s      = (state_r == ST_IDLE) && REQ_VALID;
  // PULSE lasts one cycle and is never re-entered directly, so this marks every pulse.
  assign pulse_entry_s = (state_s == ST_PULSE);

`ifdef DDR_DLY_TAP_TRACK_EN
  logic [7:0] tap_rx_r;
  logic [7:0] tap_tx_r;
  logic [7:0] tap_sel_s;

  assign tap_sel_s = sel_r ? tap_tx_r : tap_rx_r;
  // Clamp: one more step in the requested direction would leave 0..TAP_MAX.
  assign clamp_s   = dir_r ? (tap_sel_s == TAP_TOP) : (tap_sel_s == 8'd0);
  assign TAP_RX    = tap_rx_r;
  assign TAP_TX    = tap_tx_r;

  // Mirror every LOAD/MOVE pulse into the tap value of the line it was sent to.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tap_rx_r <= TAP_LOAD;
      tap_tx_r <= TAP_LOAD;
    end else if (pulse_entry_s) begin
      if (op_r) begin
        if (sel_r) begin
          tap_tx_r <= TAP_LOAD;
        end else begin
          tap_rx_r <= TAP_LOAD;
        end
      end else if (sel_r) begin
        tap_tx_r <= dir_r ? (tap_tx_r + 8'd1) : (tap_tx_r - 8'd1);
      end else begin
        tap_rx_r <= dir_r ? (tap_rx_r + 8'd1) : (tap_rx_r - 8'd1);
      end
    end else begin
      tap_rx_r <= tap_rx_r;
      tap_tx_r <= tap_tx_r;
    end
  end
`else
  // No tap trackers: nothing can clamp, and the tap outputs read 0.
  assign clamp_s = 1'b0;
  assign TAP_RX  = 8'd0;
  assign TAP_TX  = 8'd0;
`endif

  // Next-state decision and the status reported when the request finishes.
  always_comb begin
    state_s  = state_r;
    status_s = STS_OK;
    case (state_r)
      ST_IDLE: begin
        if (REQ_VALID) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!setup_end_s) begin
          state_s = ST_SETUP;
        end else if (op_r) begin
          state_s = ST_PULSE;
        end else if (rem_r == 8'd0) begin
          state_s  = ST_DONE;
          status_s = STS_OK;
        end else if (clamp_s) begin
          state_s  = ST_DONE;
          status_s = STS_CLAMP;
        end else begin
          state_s = ST_PULSE;
        end
      end
      ST_PULSE: begin
        state_s = ST_GAP;
      end
      ST_GAP: begin
        if (!gap_end_s) begin
          state_s = ST_GAP;
        end else if (oor_s) begin
          // Hardware out-of-range wins over normal completion.
          state_s  = ST_DONE;
          status_s = STS_OOR;
        end else if (op_r || (rem_r == 8'd0)) begin
          state_s  = ST_DONE;
          status_s = STS_OK;
        end else if (clamp_s) begin
          state_s  = ST_DONE;
          status_s = STS_CLAMP;
        end else begin
          state_s = ST_PULSE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus dwell counter; the counter restarts whenever a state is entered.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      if ((state_s == state_r) && ((state_r == ST_SETUP) || (state_r == ST_GAP))) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= 4'd0;
      end
    end
  end

  // Request capture and remaining-step bookkeeping.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      op_r  <= 1'b0;
      sel_r <= 1'b0;
      dir_r <= 1'b0;
      rem_r <= 8'd0;
    end else if (accept_s) begin
      op_r  <= REQ_OP;
      sel_r <= REQ_SEL;
      dir_r <= REQ_DIR;
      rem_r <= REQ_STEPS;
    end else if (pulse_entry_s && !op_r) begin
      rem_r <= rem_r - 8'd1;
    end else begin
      rem_r <= rem_r;
    end
  end

  // Registered outputs, decoded from the state being entered so they line up with it.
  // SEL/DIRECTION change only on accept and otherwise keep their last values.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      REQ_READY            <= 1'b1;
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      DONE                 <= 1'b0;
      STATUS               <= STS_OK;
      MOVES_DONE           <= 8'd0;
    end else begin
      REQ_READY       <= (state_s == ST_IDLE);
      DELAY_LINE_LOAD <= pulse_entry_s && op_r;
      DELAY_LINE_MOVE <= pulse_entry_s && !op_r;
      DONE            <= (state_s == ST_DONE);
      if (state_s == ST_DONE) begin
        STATUS <= status_s;
      end else begin
        STATUS <= STATUS;
      end
      if (accept_s) begin
        DELAY_LINE_SEL       <= REQ_SEL;
        DELAY_LINE_DIRECTION <= REQ_DIR;
        MOVES_DONE           <= 8'd0;
      end else if (pulse_entry_s && !op_r) begin
        MOVES_DONE <= MOVES_DONE + 8'd1;
      end else begin
        MOVES_DONE <= MOVES_DONE;
      end
    end
  end

endmodule
